instr_fetch_unit: RTL and testbench

Instruction fetch front end: initiator side of the instruction-memory read port. Holds the program counter, issues word-address reads (`A_InstrAddress`/`C_IMRead`), captures `D_Instruction` one cycle later, and hands instructions with their PC to decode over a valid/ready handshake. A 2-entry fetch buffer absorbs decode stalls without losing in-flight words, and a redirect input (branch/jump) flushes the buffer and restarts fetch at a new target.

---
 rtl/instr_fetch_unit.sv | 85 ++++++++
 tb/tb_instr_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: drives the PC onto the instruction-memory read port,
// captures returning words into a 2-entry buffer and presents them to decode.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] A_InstrAddress,
  output logic        C_IMRead,
  input  logic [15:0] D_Instruction,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int unsigned AW    = 16;
  localparam int unsigned IW    = 16;
  localparam int unsigned DEPTH = 2;

  logic [AW-1:0] pc;
  logic [AW-1:0] pend_pc;
  logic          pend;
  logic [1:0]    count;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [AW-1:0] fifo_pc    [DEPTH];
  logic [IW-1:0] fifo_instr [DEPTH];

  logic          pop;
  logic          push;
  logic [2:0]    occ;

  assign pop  = instr_valid && instr_ready;
  assign push = pend && !redirect;

  // Projected occupancy after this cycle; issuing only below 2 keeps the buffer from overflowing.
  assign occ      = 3'(count) + 3'(pend) - 3'(pop);
  assign C_IMRead = rst && !redirect && (occ < 3'd2);

  assign A_InstrAddress = pc;
  assign instr_valid    = (count != 2'd0);
  assign instr_out      = fifo_instr[rd_ptr];
  assign instr_pc       = fifo_pc[rd_ptr];

  // PC, outstanding-request tracking and buffer state; redirect flushes everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      pend_pc <= '0;
      pend    <= 1'b0;
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (redirect) begin
      pc     <= redirect_pc;
      pend   <= 1'b0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      pend <= C_IMRead;
      if (C_IMRead) begin
        pc      <= pc + 16'd1;
        pend_pc <= pc;
      end
      if (push) begin
        fifo_pc[wr_ptr]    <= pend_pc;
        fifo_instr[wr_ptr] <= D_Instruction;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus hand-written
// reset and PC-wrap sequences, against a one-cycle-latency memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        imread;
  logic [15:0] dinstr = '0;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  logic        rst2;
  logic [15:0] addr2;
  logic        imread2;
  logic [15:0] dinstr2 = '0;
  logic [15:0] instr_out2;
  logic [15:0] instr_pc2;
  logic        instr_valid2;
  logic        redirect2 = 1'b0;
  logic [15:0] redirect_pc2 = '0;
  logic        instr_ready2 = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .A_InstrAddress(addr), .C_IMRead(imread),
    .D_Instruction(dinstr), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst2), .A_InstrAddress(addr2), .C_IMRead(imread2),
    .D_Instruction(dinstr2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .instr_out(instr_out2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready2)
  );

  function automatic logic [15:0] mem(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  // Instruction memory: word returns in the cycle after the request.
  always @(posedge clk) begin
    if (imread)  dinstr  <= mem(addr);
    if (imread2) dinstr2 <= mem(addr2);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    logic        exp_rd;
    logic [15:0] exp_addr;
    logic        exp_v;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic rdy, input logic redir, input logic [15:0] rpc,
                              input logic exp_rd, input logic [15:0] exp_addr,
                              input logic exp_v, input logic [15:0] exp_pc);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.exp_rd = exp_rd; v.exp_addr = exp_addr; v.exp_v = exp_v; v.exp_pc = exp_pc;
    return v;
  endfunction

  task automatic check_head(input string tag, input logic exp_v, input logic [15:0] exp_pc);
    chk({tag, "_valid"}, 16'(instr_valid), 16'(exp_v));
    if (exp_v) begin
      chk({tag, "_pc"}, instr_pc, exp_pc);
      chk({tag, "_instr"}, instr_out, mem(exp_pc));
    end
  endtask

  initial begin
    // Free-run, stall at 5..10, redirect with a word in flight, then redirect+handshake and back-to-back redirects.
    vecs[0]  = mk(1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000);
    vecs[1]  = mk(1, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000);
    vecs[2]  = mk(1, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000);
    vecs[3]  = mk(1, 0, 16'h0000, 1, 16'h0003, 1, 16'h0001);
    vecs[4]  = mk(1, 0, 16'h0000, 1, 16'h0004, 1, 16'h0002);
    for (int i = 5; i <= 10; i++)
      vecs[i] = mk(0, 0, 16'h0000, 0, 16'h0005, 1, 16'h0003);
    vecs[11] = mk(1, 0, 16'h0000, 1, 16'h0005, 1, 16'h0003);
    vecs[12] = mk(1, 0, 16'h0000, 1, 16'h0006, 1, 16'h0004);
    vecs[13] = mk(1, 0, 16'h0000, 1, 16'h0007, 1, 16'h0005);
    vecs[14] = mk(0, 1, 16'h0100, 0, 16'h0008, 1, 16'h0006);
    vecs[15] = mk(1, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000);
    vecs[16] = mk(1, 0, 16'h0000, 1, 16'h0101, 0, 16'h0000);
    vecs[17] = mk(1, 0, 16'h0000, 1, 16'h0102, 1, 16'h0100);
    vecs[18] = mk(1, 1, 16'h0040, 0, 16'h0103, 1, 16'h0101);
    vecs[19] = mk(1, 1, 16'h0080, 0, 16'h0040, 0, 16'h0000);
    vecs[20] = mk(1, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000);
    vecs[21] = mk(1, 0, 16'h0000, 1, 16'h0081, 0, 16'h0000);
    vecs[22] = mk(1, 0, 16'h0000, 1, 16'h0082, 1, 16'h0080);
    vecs[23] = mk(1, 0, 16'h0000, 1, 16'h0083, 1, 16'h0081);

    rst = 1'b0; rst2 = 1'b0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_imread", 16'(imread), 16'd0);
    chk("rst_valid", 16'(instr_valid), 16'd0);
    chk("rst_instr_out", instr_out, 16'h0000);
    chk("rst_instr_pc", instr_pc, 16'h0000);

    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (i == 0) rst = 1'b1;
      instr_ready = vecs[i].rdy;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      @(negedge clk);
      chk($sformatf("v%0d_imread", i), 16'(imread), 16'(vecs[i].exp_rd));
      chk($sformatf("v%0d_addr", i), addr, vecs[i].exp_addr);
      check_head($sformatf("v%0d", i), vecs[i].exp_v, vecs[i].exp_pc);
    end

    // Fill the buffer under stall, then async reset mid-stream.
    @(posedge clk); #1;
    instr_ready = 1'b0; redirect = 1'b0;
    @(negedge clk);
    chk("fill_imread", 16'(imread), 16'd0);
    chk("fill_addr", addr, 16'h0084);
    check_head("fill", 1'b1, 16'h0082);
    @(posedge clk);
    @(negedge clk);
    chk("full_imread", 16'(imread), 16'd0);
    check_head("full", 1'b1, 16'h0082);
    #1 rst = 1'b0;
    #1;
    chk("midrst_valid", 16'(instr_valid), 16'd0);
    chk("midrst_imread", 16'(imread), 16'd0);
    chk("midrst_addr", addr, 16'h0000);
    chk("midrst_instr_out", instr_out, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    chk("restart0_imread", 16'(imread), 16'd1);
    chk("restart0_addr", addr, 16'h0000);
    check_head("restart0", 1'b0, 16'h0000);
    @(negedge clk);
    chk("restart1_addr", addr, 16'h0001);
    check_head("restart1", 1'b0, 16'h0000);
    @(negedge clk);
    check_head("restart2", 1'b1, 16'h0000);

    // RESET_PC near the top of the address space wraps to zero.
    chk("wrap_rst_addr", addr2, 16'hFFFE);
    chk("wrap_rst_imread", 16'(imread2), 16'd0);
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(negedge clk);
    chk("wrap0_imread", 16'(imread2), 16'd1);
    chk("wrap0_addr", addr2, 16'hFFFE);
    @(negedge clk);
    chk("wrap1_valid", 16'(instr_valid2), 16'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("wrap%0d_valid", k + 2), 16'(instr_valid2), 16'd1);
      chk($sformatf("wrap%0d_pc", k + 2), instr_pc2, 16'hFFFE + 16'(k));
      chk($sformatf("wrap%0d_instr", k + 2), instr_out2, mem(16'hFFFE + 16'(k)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
